// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared binary32 constants and pipeline payload types for the adder return path
package fp_pkg;
  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int MANT_W  = 28;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam int CARRY  = 27;
  localparam int HIDDEN = 26;
  localparam int GUARD  = 2;
  localparam int ROUND  = 1;
  localparam int STICKY = 0;

  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] PINF = 32'h7F800000;

  typedef struct packed {
    logic                   sign;
    logic [EXP_W-1:0]       exp;
    logic [MANT_W-1:0]      mantis;
    logic                   special_case;
    logic [EXP_W+FRAC_W:0]  special_result;
    logic                   loss;
  } s1_t;

  // exp carries one spare bit so a carry-normalised 255 is still visible as overflow
  typedef struct packed {
    logic                   sign;
    logic [EXP_W:0]         exp;
    logic [MANT_W-2:0]      mant;
    logic                   zero;
    logic                   special_case;
    logic [EXP_W+FRAC_W:0]  special_result;
    logic                   loss;
  } s2_t;
endpackage

// File: rtl/postadder_if.sv
// rtl/postadder_if.sv - input/output handshake bundle between mantissa adder, postadder and adder port
interface postadder_if;
  import fp_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic                  sign;
  logic [EXP_W-1:0]      exp;
  logic [MANT_W-1:0]     mantis;
  logic                  special_case;
  logic [EXP_W+FRAC_W:0] special_result;
  logic                  loss;
  logic                  out_valid;
  logic                  out_ready;
  logic [EXP_W+FRAC_W:0] result;
  logic                  overflow;
  logic                  inexact;

  modport master (
    output in_valid, sign, exp, mantis, special_case, special_result, loss, out_ready,
    input  in_ready, out_valid, result, overflow, inexact
  );

  modport slave (
    input  in_valid, sign, exp, mantis, special_case, special_result, loss, out_ready,
    output in_ready, out_valid, result, overflow, inexact
  );
endinterface

// File: rtl/postadder_lzc28.sv
// rtl/postadder_lzc28.sv - combinational leading-zero count of mantis[26:0], 27 when all clear
module lzc28
  import fp_pkg::*;
(
  input  logic [HIDDEN:0] m,
  output logic [4:0]      cnt
);
  // highest set bit wins because later iterations overwrite earlier ones
  always_comb begin
    cnt = 5'd27;
    for (int i = 0; i <= HIDDEN; i++) begin
      if (m[i]) cnt = 5'(HIDDEN - i);
    end
  end
endmodule

// File: rtl/postadder.sv
// rtl/postadder.sv - 3-stage normalise/round/pack for binary32 add; POSTADDER_RNE_EN selects RNE vs truncation
module postadder
  import fp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  postadder_if.slave bus
);
`ifdef POSTADDER_RNE_EN
  localparam bit RNE_ON = 1'b1;
`else
  localparam bit RNE_ON = 1'b0;
`endif

  logic v1, v2, v3;
  s1_t  s1;
  s2_t  s2, s2_n;
  logic [EXP_W+FRAC_W:0] result_q, res_n;
  logic ovf_q, inx_q, ovf_n, inx_n;
  logic advance;

  assign advance       = !v3 || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = v3;
  assign bus.result    = result_q;
  assign bus.overflow  = ovf_q;
  assign bus.inexact   = inx_q;

  logic [4:0]       lzc;
  logic [EXP_W-1:0] limit, shamt;
  logic [HIDDEN:0]  shifted;

  lzc28 u_lzc (
    .m   (s1.mantis[HIDDEN:0]),
    .cnt (lzc)
  );

  // left shift never drives the exponent below 1; whatever is still unnormalised is subnormal
  always_comb begin
    s2_n                = '0;
    shifted             = '0;
    s2_n.sign           = s1.sign;
    s2_n.special_case   = s1.special_case;
    s2_n.special_result = s1.special_result;
    s2_n.loss           = s1.loss;
    limit = (s1.exp == '0) ? '0 : s1.exp - 8'd1;
    shamt = ({3'b000, lzc} > limit) ? limit : {3'b000, lzc};
    if (s1.mantis == '0) begin
      s2_n.zero = 1'b1;
    end else if (s1.mantis[CARRY]) begin
      s2_n.mant = {s1.mantis[CARRY:2], s1.mantis[1] | s1.mantis[0]};
      s2_n.exp  = {1'b0, s1.exp} + 9'd1;
    end else begin
      shifted   = s1.mantis[HIDDEN:0] << shamt;
      s2_n.mant = shifted;
      s2_n.exp  = shifted[HIDDEN] ? {1'b0, s1.exp - shamt} : 9'd0;
    end
  end

  logic            lsb, g, rs, inc;
  logic [24:0]     sum;
  logic [EXP_W:0]  exp_f;

  always_comb begin
    lsb   = s2.mant[3];
    g     = s2.mant[GUARD];
    rs    = s2.mant[ROUND] | s2.mant[STICKY];
    inc   = g & (rs | lsb) & RNE_ON;
    sum   = {1'b0, s2.mant[HIDDEN:3]} + {24'd0, inc};
    // a subnormal that rounds into the hidden bit becomes the smallest normal
    exp_f = s2.exp + {8'd0, sum[24]} + {8'd0, (s2.exp == 9'd0) & sum[23]};
    res_n = {s2.sign, exp_f[EXP_W-1:0], sum[FRAC_W-1:0]};
    ovf_n = 1'b0;
    inx_n = g | rs | s2.loss;
    if (s2.special_case) begin
      res_n = s2.special_result;
      inx_n = 1'b0;
    end else if (s2.zero) begin
      res_n = '0;
      inx_n = s2.loss;
    end else if (exp_f >= 9'(EXP_MAX)) begin
      res_n = {s2.sign, PINF[30:0]};
      ovf_n = 1'b1;
      inx_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      s1       <= '0;
      s2       <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else if (advance) begin
      v1 <= bus.in_valid;
      v2 <= v1;
      v3 <= v2;
      if (bus.in_valid) begin
        s1 <= '{sign: bus.sign, exp: bus.exp, mantis: bus.mantis,
                special_case: bus.special_case, special_result: bus.special_result,
                loss: bus.loss};
      end
      if (v1) s2 <= s2_n;
      if (v2) begin
        result_q <= res_n;
        ovf_q    <= ovf_n;
        inx_q    <= inx_n;
      end
    end
  end
endmodule

// File: tb/tb_postadder.sv
// tb/tb_postadder.sv - randomized and directed self-checking bench for postadder against an arithmetic reference
module tb_postadder;
  import fp_pkg::*;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] mantis;
    logic        sc;
    logic [31:0] sr;
    logic        loss;
  } word_t;

  typedef struct {
    logic [31:0] r;
    logic        o;
    logic        x;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;
  bit   rne;
  exp_t sb[$];

  postadder_if bus();

  postadder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [33:0] got, input logic [33:0] want);
    checks++;
    assert (got === want) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, want);
  endtask

  // value = mantis * 2^(exp-153); round to the binary32 grid, whose ulp sits at bit q of mantis
  function automatic exp_t model(input word_t w);
    exp_t   e;
    longint n, trunc, rem, half, packed_v;
    int     p, q, b, bq;
    bit     inc;
    if (w.sc) begin
      e = '{w.sr, 1'b0, 1'b0};
      return e;
    end
    n = longint'(w.mantis);
    if (n == 0) begin
      e = '{32'h0, 1'b0, w.loss};
      return e;
    end
    p = 0;
    for (int i = 0; i < 28; i++) if (w.mantis[i]) p = i;
    b = int'(w.exp) + p - 26;
    q = (b >= 1) ? p - 23 : 4 - int'(w.exp);
    if (q > 0) begin
      trunc = n >> q;
      rem   = n - (trunc << q);
      half  = longint'(1) << (q - 1);
    end else begin
      trunc = n << (-q);
      rem   = 0;
      half  = 1;
    end
    inc = rne && ((rem > half) || (rem == half && trunc[0]));
    bq  = (b >= 1) ? b : 1;
    packed_v = (longint'(bq - 1) << 23) + trunc + longint'(inc);
    if (packed_v >= (longint'(255) << 23)) begin
      e = '{{w.sign, 31'h7F800000}, 1'b1, 1'b1};
    end else begin
      e = '{{w.sign, packed_v[30:0]}, 1'b0, (rem != 0) || w.loss};
    end
    return e;
  endfunction

  function automatic word_t mk(input logic s, input logic [7:0] ex, input logic [27:0] m, input logic l);
    word_t w;
    w = '{s, ex, m, 1'b0, 32'h0, l};
    return w;
  endfunction

  function automatic word_t rnd();
    word_t w;
    int    k;
    k        = int'($urandom_range(0, 3));
    w.sign   = 1'($urandom_range(0, 1));
    w.exp    = (k == 0) ? 8'($urandom_range(1, 30)) : 8'($urandom_range(1, 254));
    w.mantis = 28'($urandom) >> ((k == 1) ? $urandom_range(0, 27) : $urandom_range(0, 3));
    w.loss   = 1'($urandom_range(0, 3) == 0);
    w.sc     = 1'($urandom_range(0, 15) == 0);
    w.sr     = $urandom;
    return w;
  endfunction

  task automatic drive(input word_t w);
    bus.in_valid       = 1'b1;
    bus.sign           = w.sign;
    bus.exp            = w.exp;
    bus.mantis         = w.mantis;
    bus.special_case   = w.sc;
    bus.special_result = w.sr;
    bus.loss           = w.loss;
  endtask

  task automatic send(input word_t w, input exp_t e);
    bit done;
    done = 1'b0;
    drive(w);
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      if (!done) bus.out_ready = 1'b1;
    end
    checks++;
    assert (done) passed++;
    else $error("FAIL send_timeout observed=stalled expected=accepted");
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      checks++;
      assert (sb.size() > 0) passed++;
      else $error("FAIL stale_output observed=%h expected=no_word", bus.result);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("out", {bus.result, bus.overflow, bus.inexact}, {e.r, e.o, e.x});
      end
    end
  end

  initial begin
    word_t w;
    logic [33:0] held;
`ifdef POSTADDER_RNE_EN
    rne = 1'b1;
`else
    rne = 1'b0;
`endif
    bus.in_valid = 1'b0;
    bus.sign = 1'b0;
    bus.exp = 8'd0;
    bus.mantis = 28'd0;
    bus.special_case = 1'b0;
    bus.special_result = 32'd0;
    bus.loss = 1'b0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {bus.out_valid, bus.result, bus.overflow},
          {1'b0, 32'h0, 1'b0});
    check("reset_ready", {32'h0, bus.inexact, bus.in_ready}, {32'h0, 1'b0, 1'b1});
    @(posedge clk);
    #1 rst = 1'b0;

    send(mk(1'b0, 8'd127, 28'h8000000, 1'b0), '{32'h40000000, 1'b0, 1'b0});
    send(mk(1'b0, 8'd127, 28'h0000008, 1'b0), '{32'h34000000, 1'b0, 1'b0});
    send(mk(1'b0, 8'd127, 28'h4000004, 1'b0), '{32'h3F800000, 1'b0, 1'b1});
    send(mk(1'b0, 8'd127, 28'h400000C, 1'b0), '{rne ? 32'h3F800002 : 32'h3F800001, 1'b0, 1'b1});
    send(mk(1'b0, 8'd127, 28'h7FFFFFC, 1'b0), '{rne ? 32'h40000000 : 32'h3FFFFFFF, 1'b0, 1'b1});
    send(mk(1'b0, 8'd254, 28'h8000000, 1'b0), '{32'h7F800000, 1'b1, 1'b1});
    send(mk(1'b1, 8'd1, 28'h2000000, 1'b0), '{32'h80400000, 1'b0, 1'b0});
    send(mk(1'b1, 8'd90, 28'h0000000, 1'b1), '{32'h00000000, 1'b0, 1'b1});
    w = mk(1'b0, 8'd5, 28'h0000123, 1'b1);
    w.sc = 1'b1;
    w.sr = QNAN;
    send(w, '{32'h7FC00000, 1'b0, 1'b0});
    idle(5);

    // backpressure: hold the first of five results for several cycles
    for (int i = 0; i < 3; i++) begin
      w = rnd();
      send(w, model(w));
    end
    bus.out_ready = 1'b0;
    w = rnd();
    drive(w);
    @(negedge clk);
    held = {bus.out_valid, bus.result, bus.overflow};
    check("bp_first_valid", {33'h0, bus.out_valid}, {33'h0, 1'b1});
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("bp_hold", {bus.out_valid, bus.result, bus.overflow}, held);
      check("bp_in_ready", {33'h0, bus.in_ready}, 34'h0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    send(w, model(w));
    w = rnd();
    send(w, model(w));
    idle(6);

    for (int i = 0; i < 60; i++) begin
      w = rnd();
      bus.out_ready = ($urandom_range(0, 3) != 0);
      send(w, model(w));
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    bus.out_ready = 1'b1;
    idle(6);
    check("drain_empty", 34'(sb.size()), 34'h0);

    // reset with three words in flight
    for (int i = 0; i < 3; i++) begin
      w = rnd();
      send(w, model(w));
    end
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_state", {bus.out_valid, bus.result, bus.overflow},
          {1'b0, 32'h0, 1'b0});
    check("rst_mid_ready", {32'h0, bus.inexact, bus.in_ready}, {32'h0, 1'b0, 1'b1});
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    idle(6);
    send(mk(1'b0, 8'd127, 28'h8000000, 1'b0), '{32'h40000000, 1'b0, 1'b0});
    idle(6);
    check("final_empty", 34'(sb.size()), 34'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
